// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Sequencer for the instruction-fetch stage. Decides each cycle whether the PC
// and IR advance, where the next PC comes from, whether the fetched slot is
// squashed, and whether a bubble goes into ID->EX. Covers load-use stalls,
// memory-wait freezes, branch/jump/JR redirects (with a wrong-path squash of
// KILL_CYCLES slots), a redirect held across a memory wait, and HALT.
//
// Optional build macro: FETCH_CTRL_PERF_EN adds stall/redirect counters.
//
// Parameters
//   AW           PC / target address width
//   RW           register index width
//   KILL_CYCLES  fetch slots squashed per redirect (1..3)
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   mem_busy       in   memory not ready, front end frozen
//   ex_mem_read    in   EX instruction is a load
//   ex_rd          in   load destination register
//   id_rs, id_rt   in   ID source registers
//   id_uses_rs/rt  in   ID instruction reads rs / rt
//   br_taken       in   ID branch resolved taken
//   jmp            in   ID J-type jump
//   jr             in   ID jump-register
//   tgt_addr       in   branch/jump target
//   rs_val         in   JR target
//   id_halt        in   HALT in ID
//   PCWr           out  PC write enable
//   IRWrite        out  IR/NPC write enable
//   PCSrc          out  0 = PC+1, 1 = TargetAddress, 2 = Reg[Rs]
//   KILL           out  load NOP into IR
//   TargetAddress  out  redirect address to fetch mux
//   id_bubble      out  zero ID->EX control this cycle
//   halted         out  core halted
//   stall_cycles   out  (perf build) cycles with PCWr = 0 outside HALT
//   flush_count    out  (perf build) applied redirects
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int AW          = 32,
    parameter int RW          = 5,
    parameter int KILL_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_busy,
    input  logic          ex_mem_read,
    input  logic [RW-1:0] ex_rd,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic          br_taken,
    input  logic          jmp,
    input  logic          jr,
    input  logic [AW-1:0] tgt_addr,
    input  logic [AW-1:0] rs_val,
    input  logic          id_halt,
    output logic          PCWr,
    output logic          IRWrite,
    output logic [1:0]    PCSrc,
    output logic          KILL,
    output logic [AW-1:0] TargetAddress,
    output logic          id_bubble,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0]   stall_cycles,
    output logic [31:0]   flush_count,
`endif
    output logic          halted
);

    typedef enum logic [1:0] {RUN, PEND, FLUSH, HALT} state_t;

    // Remaining squash slots after the redirect cycle itself.
    localparam logic [1:0] CNT_INIT = 2'(KILL_CYCLES - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] tgt_q, tgt_nxt;
    logic [1:0]    cnt, cnt_nxt;

    logic          load_use;
    logic          redir;
    logic [AW-1:0] redir_tgt;

    logic          pc_wr_c, ir_wr_c, kill_c, bubble_c, halted_c, applied_c;
    logic [1:0]    pc_src_c;
    logic [AW-1:0] target_c;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));
    assign redir     = jr || jmp || br_taken;
    assign redir_tgt = jr ? rs_val : tgt_addr;

    always_comb begin
        pc_wr_c   = 1'b0;
        ir_wr_c   = 1'b0;
        kill_c    = 1'b0;
        bubble_c  = 1'b0;
        halted_c  = 1'b0;
        applied_c = 1'b0;
        pc_src_c  = 2'd0;
        target_c  = tgt_addr;
        state_nxt = state;
        tgt_nxt   = tgt_q;
        cnt_nxt   = cnt;

        case (state)
            RUN: begin
                if (mem_busy) begin
                    // Park the first redirect seen during a wait; a redirect
                    // behind a load-use hazard will be re-presented by decode.
                    if (redir && !load_use) begin
                        tgt_nxt   = redir_tgt;
                        state_nxt = PEND;
                    end
                end else if (load_use) begin
                    bubble_c = 1'b1;
                end else if (id_halt) begin
                    ir_wr_c   = 1'b1;
                    kill_c    = 1'b1;
                    state_nxt = HALT;
                end else if (redir) begin
                    pc_wr_c   = 1'b1;
                    ir_wr_c   = 1'b1;
                    kill_c    = 1'b1;
                    applied_c = 1'b1;
                    pc_src_c  = jr ? 2'd2 : 2'd1;
                    target_c  = redir_tgt;
                end else begin
                    pc_wr_c = 1'b1;
                    ir_wr_c = 1'b1;
                end
            end
            PEND: begin
                // Parked target is already resolved, so replay always uses
                // the TargetAddress path.
                target_c = tgt_q;
                if (!mem_busy) begin
                    pc_wr_c   = 1'b1;
                    ir_wr_c   = 1'b1;
                    kill_c    = 1'b1;
                    applied_c = 1'b1;
                    pc_src_c  = 2'd1;
                end
            end
            FLUSH: begin
                if (!mem_busy) begin
                    pc_wr_c = 1'b1;
                    ir_wr_c = 1'b1;
                    kill_c  = 1'b1;
                    cnt_nxt = cnt - 2'd1;
                    if (cnt == 2'd1) state_nxt = RUN;
                end
            end
            HALT: begin
                halted_c = 1'b1;
            end
            default: state_nxt = RUN;
        endcase

        // An applied redirect either opens a squash window or returns to RUN.
        if (applied_c) begin
            if (KILL_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = CNT_INIT;
            end else begin
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            tgt_q <= '0;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            tgt_q <= tgt_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are forced low while reset is held.
    assign PCWr          = reset && pc_wr_c;
    assign IRWrite       = reset && ir_wr_c;
    assign KILL          = reset && kill_c;
    assign id_bubble     = reset && bubble_c;
    assign halted        = reset && halted_c;
    assign PCSrc         = reset ? pc_src_c : 2'd0;
    assign TargetAddress = reset ? target_c : '0;

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((state != HALT) && !pc_wr_c && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (applied_c && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int AW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_busy, ex_mem_read, id_uses_rs, id_uses_rt;
    logic          br_taken, jmp, jr, id_halt;
    logic [RW-1:0] ex_rd, id_rs, id_rt;
    logic [AW-1:0] tgt_addr, rs_val;

    logic          pcwr_o [2];
    logic          irw_o  [2];
    logic [1:0]    src_o  [2];
    logic          kill_o [2];
    logic [AW-1:0] ta_o   [2];
    logic          bub_o  [2];
    logic          hlt_o  [2];

    int total = 0;
    int bad   = 0;

    // Reference model state: halted flag, parked redirect, squash slots left.
    int            kc     [2] = '{1, 3};
    bit            m_halt [2];
    bit            m_pend [2];
    logic [AW-1:0] m_ptgt [2];
    int            m_kill [2];

    always #5 clk = ~clk;

    fetch_ctrl #(.AW(AW), .RW(RW), .KILL_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .mem_busy(mem_busy), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .br_taken(br_taken), .jmp(jmp), .jr(jr),
        .tgt_addr(tgt_addr), .rs_val(rs_val), .id_halt(id_halt),
        .PCWr(pcwr_o[0]), .IRWrite(irw_o[0]), .PCSrc(src_o[0]), .KILL(kill_o[0]),
        .TargetAddress(ta_o[0]), .id_bubble(bub_o[0]), .halted(hlt_o[0]));

    fetch_ctrl #(.AW(AW), .RW(RW), .KILL_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .mem_busy(mem_busy), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .br_taken(br_taken), .jmp(jmp), .jr(jr),
        .tgt_addr(tgt_addr), .rs_val(rs_val), .id_halt(id_halt),
        .PCWr(pcwr_o[1]), .IRWrite(irw_o[1]), .PCSrc(src_o[1]), .KILL(kill_o[1]),
        .TargetAddress(ta_o[1]), .id_bubble(bub_o[1]), .halted(hlt_o[1]));

    task automatic check(input string tag, input int inst,
                         input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[K=%0d] observed=%h expected=%h", tag, kc[inst], obs, exp);
        end
    endtask

    task automatic idle();
        mem_busy = 0; ex_mem_read = 0; id_uses_rs = 0; id_uses_rt = 0;
        br_taken = 0; jmp = 0; jr = 0; id_halt = 0;
        ex_rd = '0; id_rs = '0; id_rt = '0;
        tgt_addr = 32'h1234; rs_val = 32'h5678;
    endtask

    // Inputs are set just after a falling edge; compare, advance the model
    // to the coming rising edge, then wait for the next falling edge.
    task automatic tick();
        logic          lu, rd;
        logic [AW-1:0] rt;
        logic          e_pcwr, e_irw, e_kill, e_bub, e_hlt;
        logic [1:0]    e_src;
        logic [AW-1:0] e_ta;
        #1;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        rd = jr || jmp || br_taken;
        rt = jr ? rs_val : tgt_addr;
        for (int i = 0; i < 2; i++) begin
            e_pcwr = 0; e_irw = 0; e_kill = 0; e_bub = 0; e_hlt = 0;
            e_src = 0; e_ta = tgt_addr;
            if (!reset) begin
                e_ta = '0;
                m_halt[i] = 0; m_pend[i] = 0; m_ptgt[i] = '0; m_kill[i] = 0;
            end else if (m_halt[i]) begin
                e_hlt = 1;
            end else if (m_pend[i]) begin
                e_ta = m_ptgt[i];
                if (!mem_busy) begin
                    e_pcwr = 1; e_irw = 1; e_kill = 1; e_src = 1;
                    m_pend[i] = 0; m_kill[i] = kc[i] - 1;
                end
            end else if (m_kill[i] > 0) begin
                if (!mem_busy) begin
                    e_pcwr = 1; e_irw = 1; e_kill = 1;
                    m_kill[i]--;
                end
            end else if (mem_busy) begin
                if (rd && !lu) begin
                    m_pend[i] = 1; m_ptgt[i] = rt;
                end
            end else if (lu) begin
                e_bub = 1;
            end else if (id_halt) begin
                e_irw = 1; e_kill = 1; m_halt[i] = 1;
            end else if (rd) begin
                e_pcwr = 1; e_irw = 1; e_kill = 1;
                e_src = jr ? 2 : 1; e_ta = rt;
                m_kill[i] = kc[i] - 1;
            end else begin
                e_pcwr = 1; e_irw = 1;
            end
            check("PCWr",          i, pcwr_o[i], e_pcwr);
            check("IRWrite",       i, irw_o[i],  e_irw);
            check("PCSrc",         i, src_o[i],  e_src);
            check("KILL",          i, kill_o[i], e_kill);
            check("TargetAddress", i, ta_o[i],   e_ta);
            check("id_bubble",     i, bub_o[i],  e_bub);
            check("halted",        i, hlt_o[i],  e_hlt);
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            m_halt[i] = 0; m_pend[i] = 0; m_ptgt[i] = '0; m_kill[i] = 0;
        end

        // reset held, then idle fetch
        tick(); tick();
        reset = 1;
        tick(); tick(); tick(); tick();

        // load-use stall for one cycle
        ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
        tick();
        idle(); tick();
        // same hazard against r0: no stall
        ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
        tick();
        idle(); tick();
        // load-use through rt
        ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1; br_taken = 1;
        tick();
        idle(); tick();

        // taken branch
        br_taken = 1; tgt_addr = 32'h40;
        tick();
        idle(); tick(); tick(); tick();

        // priority: jr over jmp over branch
        jr = 1; jmp = 1; br_taken = 1; rs_val = 32'hA0; tgt_addr = 32'hB0;
        tick();
        idle(); tick(); tick(); tick();
        jmp = 1; br_taken = 1; tgt_addr = 32'hC0;
        tick();
        idle(); tick(); tick(); tick();

        // JR during a 4-cycle memory wait, replayed afterwards
        mem_busy = 1; jr = 1; rs_val = 32'h80;
        tick();
        jr = 0; br_taken = 1; tgt_addr = 32'h99;
        tick(); tick(); tick();
        idle(); tick(); tick(); tick(); tick();

        // memory wait inside the squash window
        jmp = 1; tgt_addr = 32'h200;
        tick();
        idle(); mem_busy = 1; tick(); tick();
        mem_busy = 0; tick(); tick(); tick();

        // reset pulsed in the second squash cycle
        br_taken = 1; tgt_addr = 32'h300;
        tick();
        idle(); tick();
        reset = 0; tick();
        reset = 1; tick(); tick();

        // halt, then noisy inputs, then reset exit
        id_halt = 1;
        tick();
        idle();
        br_taken = 1; jr = 1; tick();
        idle(); mem_busy = 1; tick();
        idle(); tick();
        reset = 0; tick();
        reset = 1; tick(); tick();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom % 40) != 0;
            mem_busy    = ($urandom % 4) == 0;
            ex_mem_read = ($urandom % 3) == 0;
            ex_rd       = RW'($urandom % 4);
            id_rs       = RW'($urandom % 4);
            id_rt       = RW'($urandom % 4);
            id_uses_rs  = $urandom % 2;
            id_uses_rt  = $urandom % 2;
            br_taken    = ($urandom % 5) == 0;
            jmp         = ($urandom % 8) == 0;
            jr          = ($urandom % 8) == 0;
            id_halt     = ($urandom % 70) == 0;
            tgt_addr    = $urandom;
            rs_val      = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
